serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor (diff = a - b) built around the 1-bit borrow subtractor cell.

---
 rtl/serial_subtractor_pkg.sv | 5 +
 rtl/serial_subtractor_cell.sv | 11 +
 rtl/serial_subtractor.sv | 70 +++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM encoding and default width for the serial arithmetic units
package serial_subtractor_pkg;
  localparam int SER_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_subtractor_cell.sv
// carrylookaheadsub: 1-bit full subtractor cell, purely combinational
module carrylookaheadsub (
  output logic out,
  output logic Bout,
  input  logic A,
  input  logic B,
  input  logic Bin
);
  assign out  = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock through a single borrow cell
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
  logic [CNT_W-1:0] cnt;
  logic brw, d, bo, last;
  carrylookaheadsub u_cell (.out(d), .Bout(bo), .A(a_sh[0]), .B(b_sh[0]), .Bin(brw));
  assign res_nx = {d, res[WIDTH-1:1]};
  assign last   = cnt == CNT_W'(WIDTH - 1);
  assign busy   = state == SHIFT || state == DONE;
  assign done   = state == DONE;
  // DONE and the unused encoding both fall back to IDLE
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = start ? SHIFT : IDLE;
      SHIFT:   nxt = last ? DONE : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        res  <= '0;
        brw  <= 1'b0;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        res  <= res_nx;
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        brw  <= bo;
        cnt  <= cnt + CNT_W'(1);
        if (last) begin
          diff       <= res_nx;
          borrow_out <= bo;
          zero       <= ~|res_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table plus scoreboard check of the serial subtractor
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic busy, done, borrow_out, zero;
  int total = 0, bad = 0, n_done = 0;
  typedef struct { logic [7:0] diff; logic bo; logic z; } exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] diff; logic bo; logic z; } vec_t;
  exp_t sb[$];
  vec_t tbl[8];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .borrow_out(borrow_out), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("diff", diff, e.diff);
        chk("borrow_out", borrow_out, e.bo);
        chk("zero", zero, e.z);
      end
    end
  end

  // drives one op from cycle 0; returns on the negedge where done is seen
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input exp_t e,
                        input bit hold, input bit poke);
    int cyc = 0, bcnt = 0;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    sb.push_back(e);
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (!hold && cyc == 1) begin
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (poke && cyc == 3) begin
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
      end
      if (poke && cyc == 4) start = 1'b0;
      if (done) break;
    end
    chk("latency", cyc, 9);
    chk("busy_span", bcnt, 9);
  endtask

  function automatic exp_t model(input logic [7:0] va, input logic [7:0] vb);
    exp_t e;
    e.diff = va - vb;
    e.bo = va < vb;
    e.z = va == vb;
    return e;
  endfunction

  initial begin
    int d0;
    exp_t e;
    tbl = '{
      '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0},
      '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0},
      '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1},
      '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0},
      '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0},
      '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0},
      '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1},
      '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0}
    };
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    foreach (tbl[i]) begin
      e = '{tbl[i].diff, tbl[i].bo, tbl[i].z};
      run_op(tbl[i].a, tbl[i].b, e, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_done_busy", busy, 0);
    end

    // start while busy is ignored: one done, result of the first op
    d0 = n_done;
    run_op(8'h05, 8'h03, '{8'h02, 1'b0, 1'b0}, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    chk("poke_single_done", n_done - d0, 1);
    chk("poke_diff_hold", diff, 8'h02);
    chk("poke_idle", busy, 0);

    // async reset mid-operation
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    sb.push_back('{8'h0F, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    sb.delete();
    d0 = n_done;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("arst_no_done", n_done - d0, 0);
    run_op(8'h33, 8'h11, '{8'h22, 1'b0, 1'b0}, 1'b0, 1'b0);

    // back-to-back with start held high, random operands
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (i % 17 == 0) ? ra : 8'($urandom);
      run_op(ra, rb, model(ra, rb), 1'b1, 1'b0);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
